// File: rtl/msg_tx_pkg.sv
// Shared constants and helpers for the host-bound measurement message frame.
package msg_tx_pkg;

    localparam logic [7:0]  FRAME_HDR   = 8'hA5;
    localparam int unsigned FRAME_BYTES = 12;
    localparam int unsigned MSG_W       = 33;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter; tx is bit 0 of the frame shift register, so it is always registered.
module uart_byte_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_busy,
    output logic       byte_done
);

    localparam int unsigned      CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_EARLY = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] baud_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [9:0]       shreg_q;
    logic             busy_q;
    logic             stop_bit;
    logic             last_clk;

    assign stop_bit  = busy_q && (bit_cnt_q == 4'd9);
    assign last_clk  = stop_bit && (baud_cnt_q == BAUD_LAST);
    // Fires one clock early so a caller with a registered start can chain bytes gap-free.
    assign byte_done = stop_bit && (baud_cnt_q == BAUD_EARLY);
    assign tx        = shreg_q[0];
    assign byte_busy = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q    <= '1;
            busy_q     <= 1'b0;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
        end else if (start && (!busy_q || last_clk)) begin
            shreg_q    <= {1'b1, data, 1'b0};
            busy_q     <= 1'b1;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
        end else if (busy_q) begin
            if (baud_cnt_q == BAUD_LAST) begin
                baud_cnt_q <= '0;
                if (bit_cnt_q == 4'd9) begin
                    busy_q <= 1'b0;
                end else begin
                    shreg_q   <= {1'b1, shreg_q[9:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else begin
                baud_cnt_q <= baud_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/msg_uart_tx.sv
// Latches two result messages and sends them as one XOR-checksummed 12-byte UART frame.
module msg_uart_tx
    import msg_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             send,
    input  logic [MSG_W-1:0] msg0,
    input  logic [MSG_W-1:0] msg1,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam logic [3:0]  LAST_IDX     = 4'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWait, StFin} state_e;

    state_e           state_q;
    logic [3:0]       idx_q;
    logic [7:0]       csum_q;
    logic [7:0]       byte_q;
    logic             start_q;
    logic             busy_q;
    logic             done_q;
    logic [MSG_W-1:0] msg0_q;
    logic [MSG_W-1:0] msg1_q;
    logic [3:0]       nxt_idx;
    logic [7:0]       nxt_byte;
    logic             byte_busy;
    logic             byte_done;

    always_comb begin
        nxt_idx  = idx_q + 4'd1;
        nxt_byte = csum_q;
        case (nxt_idx)
            4'd1:    nxt_byte = {7'b0, msg0_q[MSG_W-1]};
            4'd2:    nxt_byte = msg0_q[31:24];
            4'd3:    nxt_byte = msg0_q[23:16];
            4'd4:    nxt_byte = msg0_q[15:8];
            4'd5:    nxt_byte = msg0_q[7:0];
            4'd6:    nxt_byte = {7'b0, msg1_q[MSG_W-1]};
            4'd7:    nxt_byte = msg1_q[31:24];
            4'd8:    nxt_byte = msg1_q[23:16];
            4'd9:    nxt_byte = msg1_q[15:8];
            4'd10:   nxt_byte = msg1_q[7:0];
            default: nxt_byte = csum_q;
        endcase
    end

    // Next byte is selected on the byte_done edge so start lands in the stop bit's last clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            csum_q  <= '0;
            byte_q  <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            msg0_q  <= '0;
            msg1_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (send && !byte_busy) begin
                        msg0_q  <= msg0;
                        msg1_q  <= msg1;
                        idx_q   <= '0;
                        csum_q  <= '0;
                        byte_q  <= FRAME_HDR;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    start_q <= 1'b0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (byte_done) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= StFin;
                        end else begin
                            idx_q   <= nxt_idx;
                            byte_q  <= nxt_byte;
                            if (nxt_idx != LAST_IDX) begin
                                csum_q <= csum_q ^ nxt_byte;
                            end
                            start_q <= 1'b1;
                            state_q <= StLoad;
                        end
                    end
                end
                StFin: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_q),
        .data     (byte_q),
        .tx       (tx),
        .byte_busy(byte_busy),
        .byte_done(byte_done)
    );

endmodule
